modexp_bit_sequencer: RTL and testbench
=======================================

Name: modexp_bit_sequencer

Overview:
- Parametrised successor to the fixed 6-bit key-bit counter in the RSA datapath.
- Walks the exponent bit by bit and issues SQUARE / MULTIPLY operation requests to the modular-multiplier datapath over a req/ack handshake.
- Supports run-time bit length, left-to-right (MSB-first) and right-to-left (LSB-first) scan modes, abort, and completion/statistics outputs.
- Sits between the RSA top-level control and the modular multiplier.

Parameters:
- W, 32, exponent width in bits (>=2).
- LW, $clog2(W+1), width of bit-count and index fields.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle pulse; latches exp/nbits/mode; honoured only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE with no done pulse.
- exp  input  W  exponent (key), sampled on accepted start.
- nbits  input  LW  number of valid exponent bits [nbits-1:0], sampled on start.
- mode  input  1  0 = left-to-right (MSB-first), 1 = right-to-left (LSB-first), sampled on start.
- op_req  output  1  operation request to multiplier.
- op_type  output  1  0 = SQUARE, 1 = MULTIPLY; valid while op_req=1.
- op_ack  input  1  multiplier completion; meaningful only while op_req=1.
- bit_idx  output  LW  index of exponent bit currently being processed.
- busy  output  1  high from the cycle after an accepted start until done/abort.
- done  output  1  one-cycle completion pulse.
- mul_count  output  LW  number of MULTIPLY ops completed in the current or last run.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; op_req=0, op_type=0, bit_idx=0, busy=0, done=0, mul_count=0; latched exp/nbits/mode cleared.
- States: IDLE, ISSUE, WAIT_ACK, GAP, FINISH.
- IDLE + start=1 (cycle t):
  - Latch exp, mode, and n = min(nbits, W).
  - Clear mul_count.
  - busy=1 from t+1.
  - If n=0: go to FINISH; done=1 at t+1, busy low at t+2, no ops issued.
  - Otherwise go to ISSUE; first op_req=1 at t+1.
  - Start initial bit_idx: n-1 for mode 0, 0 for mode 1.
- Op order, mode 0, for i = n-1 down to 0:
  - SQUARE.
  - Then MULTIPLY if exp[i]=1.
- Op order, mode 1, for i = 0 up to n-1:
  - MULTIPLY if exp[i]=1.
  - Then SQUARE, except on the final bit (i=n-1), where the SQUARE is omitted.
- Handshake:
  - op_req and op_type stay constant until op_ack=1 is sampled with op_req=1.
  - op_req=0 in the cycle after ack (GAP). The next op_req asserts the following cycle. Minimum op spacing is therefore two cycles.
  - op_ack while op_req=0 is ignored.
  - No timeout.
- bit_idx holds during all ops for a bit and advances in the GAP after that bit's last op.
- mul_count increments on each acked MULTIPLY. It saturates at 2^LW-1 (cannot overflow for legal n).
- Completion:
  - The final ack at cycle t gives done=1 at t+1 (FINISH), with op_req=0.
  - busy=0 and state IDLE at t+2.
  - mul_count and bit_idx hold until the next start.
- Mid-run events:
  - start while busy: ignored. Latched values are unchanged.
  - abort (any state except IDLE): next cycle IDLE, op_req=0, busy=0, done=0, mul_count held.
  - abort wins over op_ack in the same cycle.
  - abort and start together in IDLE: start wins.
- Async reset mid-operation forces reset values immediately. The multiplier is responsible for discarding its in-flight op.
- done and start in the same FINISH cycle: start is ignored; it must come from IDLE.

Test Plan:
1. W=8, exp=8'b0000_1011, nbits=4, mode=0, ack 3 cycles after each req -> op_type sequence S,M,S,S,M,S,M (7 ops); mul_count=3; single done pulse; busy falls the cycle after done.
2. Same exp/nbits, mode=1 -> sequence M,S,M,S,S,M (6 ops, no trailing S); bit_idx steps 0,1,2,3; mul_count=3.
3. nbits=0 -> done at t+1 with no op_req. Separately nbits=12 with W=8 -> clamped to 8; exp=8'hFF, mode=0 gives 16 ops and mul_count=8.
4. op_ack held high continuously (ack same cycle as req) -> op_req pattern 1,0,1,0,...; no op skipped or duplicated. A stray op_ack during GAP is ignored.
5. abort asserted in WAIT_ACK of the 3rd op, together with op_ack -> IDLE next cycle, no done, mul_count reflects only acked MULTIPLY ops before abort. A start pulse while busy is ignored.
6. rst_n asserted low mid-run, asynchronous to clk -> all outputs at reset values before the next clk edge. A new start after rst_n deasserts runs case 1 correctly.

Source files
------------

// File: rtl/modexp_bit_sequencer.sv
// Exponent bit walker: issues SQUARE/MULTIPLY requests to the modular multiplier
// over a req/ack handshake, MSB-first or LSB-first, with abort and run statistics.
module modexp_bit_sequencer #(
  parameter int W  = 32,
  parameter int LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  exp,
  input  logic [LW-1:0] nbits,
  input  logic          mode,
  output logic          op_req,
  output logic          op_type,
  input  logic          op_ack,
  output logic [LW-1:0] bit_idx,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] mul_count
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_GAP, S_FINISH} state_t;

  localparam logic OP_SQ  = 1'b0;
  localparam logic OP_MUL = 1'b1;
  localparam int   XW     = 2 ** LW;

  state_t        r_state;
  logic [W-1:0]  r_exp;
  logic [LW-1:0] r_n;
  logic          r_mode;
  logic          r_op_req;
  logic          r_op_type;
  logic [LW-1:0] r_bit_idx;
  logic          r_busy;
  logic          r_done;
  logic [LW-1:0] r_mul_count;

  logic [LW-1:0] w_n_clamp;
  logic [XW-1:0] w_exp_ext;
  logic [LW-1:0] w_idx_inc;
  logic [LW-1:0] w_idx_dec;
  logic [LW-1:0] w_last_idx;
  logic          w_fin;
  logic [LW-1:0] w_next_idx;
  logic          w_next_type;
  logic          w_start_empty;

  assign w_n_clamp  = (nbits > LW'(W)) ? LW'(W) : nbits;
  // Zero-padded so any LW-bit index is in range.
  assign w_exp_ext  = {{(XW - W){1'b0}}, r_exp};
  assign w_idx_inc  = r_bit_idx + LW'(1);
  assign w_idx_dec  = r_bit_idx - LW'(1);
  assign w_last_idx = r_n - LW'(1);

  // LSB-first with a single zero bit has nothing to issue at all.
  assign w_start_empty = (w_n_clamp == '0) || (mode && !exp[0] && (w_n_clamp == LW'(1)));

  // Next operation after the one currently being acknowledged.
  always_comb begin
    w_fin       = 1'b0;
    w_next_idx  = r_bit_idx;
    w_next_type = OP_SQ;
    if (!r_mode) begin
      if ((r_op_type == OP_SQ) && w_exp_ext[r_bit_idx]) begin
        w_next_type = OP_MUL;
      end else if (r_bit_idx == '0) begin
        w_fin = 1'b1;
      end else begin
        w_next_idx  = w_idx_dec;
        w_next_type = OP_SQ;
      end
    end else begin
      if ((r_op_type == OP_MUL) && (r_bit_idx != w_last_idx)) begin
        w_next_type = OP_SQ;
      end else if (r_bit_idx == w_last_idx) begin
        w_fin = 1'b1;
      end else begin
        w_next_idx = w_idx_inc;
        if (w_exp_ext[w_idx_inc]) begin
          w_next_type = OP_MUL;
        end else if (w_idx_inc != w_last_idx) begin
          w_next_type = OP_SQ;
        end else begin
          w_fin = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_exp       <= '0;
      r_n         <= '0;
      r_mode      <= 1'b0;
      r_op_req    <= 1'b0;
      r_op_type   <= OP_SQ;
      r_bit_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mul_count <= '0;
    end else if ((r_state != S_IDLE) && abort) begin
      r_state  <= S_IDLE;
      r_op_req <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_exp       <= exp;
            r_mode      <= mode;
            r_n         <= w_n_clamp;
            r_mul_count <= '0;
            r_busy      <= 1'b1;
            if (w_start_empty) begin
              r_state   <= S_FINISH;
              r_done    <= 1'b1;
              r_bit_idx <= '0;
            end else begin
              r_state   <= S_ISSUE;
              r_op_req  <= 1'b1;
              r_bit_idx <= mode ? '0 : (w_n_clamp - LW'(1));
              r_op_type <= mode & exp[0];
            end
          end
        end
        S_ISSUE, S_WAIT_ACK: begin
          if (op_ack) begin
            r_op_req <= 1'b0;
            if ((r_op_type == OP_MUL) && (r_mul_count != {LW{1'b1}})) begin
              r_mul_count <= r_mul_count + LW'(1);
            end
            if (w_fin) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_GAP;
              r_bit_idx <= w_next_idx;
              r_op_type <= w_next_type;
            end
          end else begin
            r_state <= S_WAIT_ACK;
          end
        end
        S_GAP: begin
          r_op_req <= 1'b1;
          r_state  <= S_ISSUE;
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign op_req    = r_op_req;
  assign op_type   = r_op_type;
  assign bit_idx   = r_bit_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign mul_count = r_mul_count;

endmodule

// File: tb/tb_modexp_bit_sequencer.sv
// Directed bench for modexp_bit_sequencer (W=8): op order, handshake spacing,
// clamping, abort and asynchronous reset, with hand-computed expectations.
module tb_modexp_bit_sequencer;

  localparam int W  = 8;
  localparam int LW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [W-1:0]  exp_i;
  logic [LW-1:0] nbits_i;
  logic          mode_i;
  logic          op_req;
  logic          op_type;
  logic          op_ack;
  logic [LW-1:0] bit_idx;
  logic          busy;
  logic          done;
  logic [LW-1:0] mul_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Acknowledge responder and op recorder state
  int       ack_lat  = 3;
  logic     ack_hold = 1'b0;
  int       lat_cnt  = 0;
  int       req_hi   = 0;
  bit       ops_q[$];
  bit [3:0] idx_q[$];

  modexp_bit_sequencer #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .exp       (exp_i),
    .nbits     (nbits_i),
    .mode      (mode_i),
    .op_req    (op_req),
    .op_type   (op_type),
    .op_ack    (op_ack),
    .bit_idx   (bit_idx),
    .busy      (busy),
    .done      (done),
    .mul_count (mul_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives op_ack on the falling edge; records each op that will be acked at the next rising edge.
  always @(negedge clk) begin
    if (op_req) req_hi++;
    if (ack_hold) begin
      op_ack = 1'b1;
      if (op_req) begin
        ops_q.push_back(op_type);
        idx_q.push_back(bit_idx);
      end
    end else if (op_req) begin
      if (lat_cnt == ack_lat) begin
        op_ack = 1'b1;
        ops_q.push_back(op_type);
        idx_q.push_back(bit_idx);
        lat_cnt = 0;
      end else begin
        op_ack = 1'b0;
        lat_cnt++;
      end
    end else begin
      op_ack  = 1'b0;
      lat_cnt = 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] pack_ops();
    logic [31:0] v = '0;
    foreach (ops_q[i]) if (i < 32) v[i] = ops_q[i];
    return v;
  endfunction

  function automatic logic [31:0] pack_idx();
    logic [31:0] v = '0;
    foreach (idx_q[i]) if (i < 8) v[i*4 +: 4] = idx_q[i];
    return v;
  endfunction

  // Runs one complete exponent and checks done/busy timing around completion.
  task automatic run_case(input string tag, input logic [7:0] e, input logic [3:0] nb,
                          input logic m, input int lat, input logic hold, output int cyc);
    int k;
    ops_q.delete();
    idx_q.delete();
    ack_lat  = lat;
    ack_hold = hold;
    @(negedge clk);
    req_hi  = 0;
    exp_i   = e;
    nbits_i = nb;
    mode_i  = m;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val({tag, "_busy_t1"}, busy, 1);
    for (k = 0; k < 500; k++) begin
      if (done) break;
      @(negedge clk);
    end
    check_val({tag, "_no_timeout"}, (k < 500), 1);
    cyc = k;
    check_val({tag, "_busy_at_done"}, busy, 1);
    check_val({tag, "_req_at_done"}, op_req, 0);
    @(negedge clk);
    check_val({tag, "_done_single"}, done, 0);
    check_val({tag, "_busy_after"}, busy, 0);
    ack_hold = 1'b0;
    $display("run %s: ops=%0d mul_count=%0d bit_idx=%0d cycles=%0d", tag, ops_q.size(), mul_count, bit_idx, cyc);
  endtask

  initial begin
    int cyc;
    int k;
    bit started2;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    exp_i   = '0;
    nbits_i = '0;
    mode_i  = 1'b0;
    op_ack  = 1'b0;

    #12;
    check_val("rst_req", op_req, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_mul", mul_count, 0);
    check_val("rst_idx", bit_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // MSB-first, 1011: S,M,S,S,M,S,M
    run_case("c1", 8'b0000_1011, 4'd4, 1'b0, 3, 1'b0, cyc);
    check_val("c1_nops", ops_q.size(), 7);
    check_val("c1_seq", pack_ops(), 32'h52);
    check_val("c1_idx", pack_idx(), 32'h0011233);
    check_val("c1_mul", mul_count, 3);
    check_val("c1_idx_hold", bit_idx, 0);

    // LSB-first, 1011: M,S,M,S,S,M
    run_case("c2", 8'b0000_1011, 4'd4, 1'b1, 3, 1'b0, cyc);
    check_val("c2_nops", ops_q.size(), 6);
    check_val("c2_seq", pack_ops(), 32'h25);
    check_val("c2_idx", pack_idx(), 32'h321100);
    check_val("c2_mul", mul_count, 3);
    check_val("c2_idx_hold", bit_idx, 3);

    // Zero bits: done one cycle after start, no ops
    run_case("c3a", 8'hFF, 4'd0, 1'b0, 3, 1'b0, cyc);
    check_val("c3a_latency", cyc, 0);
    check_val("c3a_nops", ops_q.size(), 0);
    check_val("c3a_reqs", req_hi, 0);
    check_val("c3a_mul", mul_count, 0);

    // nbits=12 clamps to 8: 16 ops S,M alternating
    run_case("c3b", 8'hFF, 4'd12, 1'b0, 1, 1'b0, cyc);
    check_val("c3b_nops", ops_q.size(), 16);
    check_val("c3b_seq", pack_ops(), 32'hAAAA);
    check_val("c3b_mul", mul_count, 8);

    // op_ack held high, including stray ack during GAP
    run_case("c4", 8'b0000_1011, 4'd4, 1'b0, 0, 1'b1, cyc);
    check_val("c4_nops", ops_q.size(), 7);
    check_val("c4_seq", pack_ops(), 32'h52);
    check_val("c4_req_cycles", req_hi, 7);
    check_val("c4_cycles", cyc, 13);
    check_val("c4_mul", mul_count, 3);

    // Abort with ack on the 3rd op; start while busy ignored
    ops_q.delete();
    idx_q.delete();
    ack_lat  = 3;
    ack_hold = 1'b0;
    started2 = 1'b0;
    @(negedge clk);
    exp_i   = 8'b0000_1011;
    nbits_i = 4'd4;
    mode_i  = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      start = 1'b0;
      if (ops_q.size() == 1 && !started2) begin
        exp_i    = 8'hFF;
        nbits_i  = 4'd8;
        mode_i   = 1'b1;
        start    = 1'b1;
        started2 = 1'b1;
      end
      if (ops_q.size() == 3) break;
    end
    check_val("c5_reach_op3", ops_q.size(), 3);
    check_val("c5_op2_type", ops_q[1], 1);
    check_val("c5_op3_idx", bit_idx, 2);
    check_val("c5_ack_high", op_ack, 1);
    abort = 1'b1;
    @(negedge clk);
    #1;
    abort = 1'b0;
    check_val("c5_req", op_req, 0);
    check_val("c5_busy", busy, 0);
    check_val("c5_done", done, 0);
    check_val("c5_mul", mul_count, 1);
    k = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (done || op_req || busy) k++;
    end
    check_val("c5_stays_idle", k, 0);
    check_val("c5_mul_held", mul_count, 1);
    $display("run c5: aborted after %0d recorded ops, mul_count=%0d", ops_q.size(), mul_count);

    // Asynchronous reset mid-run
    ops_q.delete();
    idx_q.delete();
    @(negedge clk);
    exp_i   = 8'b0000_1011;
    nbits_i = 4'd4;
    mode_i  = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ops_q.size() >= 2 && op_req) break;
    end
    check_val("c6_mid_run", (k < 200), 1);
    check_val("c6_mul_before", mul_count, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("c6_rst_req", op_req, 0);
    check_val("c6_rst_type", op_type, 0);
    check_val("c6_rst_busy", busy, 0);
    check_val("c6_rst_mul", mul_count, 0);
    check_val("c6_rst_idx", bit_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("run c6: async reset applied mid-run");

    run_case("c6r", 8'b0000_1011, 4'd4, 1'b0, 3, 1'b0, cyc);
    check_val("c6r_seq", pack_ops(), 32'h52);
    check_val("c6r_nops", ops_q.size(), 7);
    check_val("c6r_mul", mul_count, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
